// File: rtl/data_mover_engine.sv
// Avalon-MM memory-to-memory copy engine: CSR slave, pipelined read master,
// credit-limited data FIFO and write master, with DONE status and level interrupt.
module data_mover_engine #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 24,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        csr_address,
  input  logic              csr_read,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  output logic [ADDR_W-1:0] rd_address,
  output logic              rd_read,
  input  logic              rd_waitrequest,
  input  logic [DATA_W-1:0] rd_readdata,
  input  logic              rd_readdatavalid,
  output logic [ADDR_W-1:0] wr_address,
  output logic              wr_write,
  output logic [DATA_W-1:0] wr_writedata,
  input  logic              wr_waitrequest,
  output logic              irq
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WCNT_W = LEN_W - 2;
  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);
  localparam logic [CNT_W:0]    DEPTH_C    = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [ADDR_W-1:0]   src_r, src_nxt_s, dst_r, dst_nxt_s;
  logic [LEN_W-1:0]    len_r, len_nxt_s;
  logic                irq_en_r, irq_en_nxt_s, done_r, done_nxt_s;
  logic [ADDR_W-1:0]   rd_ptr_r, rd_ptr_nxt_s, wr_ptr_r, wr_ptr_nxt_s;
  logic [WCNT_W-1:0]   rd_rem_r, rd_rem_nxt_s, wr_rem_r, wr_rem_nxt_s;
  logic [CNT_W-1:0]    outst_r, outst_nxt_s, count_r, count_nxt_s, remain_s;
  logic [PTR_W-1:0]    head_r, head_nxt_s, tail_r, tail_nxt_s;
  logic [DATA_W-1:0]   mem_r [FIFO_DEPTH];
  logic [DATA_W-1:0]   wr_data_r, wr_data_nxt_s;
  logic                rd_read_r, rd_read_nxt_s, wr_write_r, wr_write_nxt_s;
  logic                irq_r, irq_nxt_s;
  logic [31:0]         csr_rdata_r, csr_rdata_nxt_s;
  logic [CNT_W:0]      credit_s;
  logic [WCNT_W-1:0]   word_cnt_s;
  logic                ctrl_wr_s, go_s, rd_acc_s, wr_acc_s, push_s, last_wr_s;

  assign word_cnt_s = len_r[LEN_W-1:2];
  assign ctrl_wr_s  = csr_write && (csr_address == 2'd3);
  assign go_s       = ctrl_wr_s && csr_writedata[0];
  assign rd_acc_s   = rd_read_r && !rd_waitrequest;
  assign wr_acc_s   = wr_write_r && !wr_waitrequest;
  // Responses are only accepted while reads are outstanding, so stale ones after reset are dropped.
  assign push_s     = rd_readdatavalid && (outst_r != {CNT_W{1'b0}});
  assign last_wr_s  = wr_acc_s && (wr_rem_r == WCNT_W'(1));

  // Control path: CSR registers, transfer FSM, pointers and remaining counts.
  always_comb begin
    state_nxt_s  = state_r;
    src_nxt_s    = src_r;
    dst_nxt_s    = dst_r;
    len_nxt_s    = len_r;
    irq_en_nxt_s = irq_en_r;
    done_nxt_s   = done_r;
    rd_ptr_nxt_s = rd_ptr_r;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_rem_nxt_s = rd_rem_r;
    wr_rem_nxt_s = wr_rem_r;

    if (csr_write && (state_r == ST_IDLE)) begin
      case (csr_address)
        2'd0:    src_nxt_s = {csr_writedata[ADDR_W-1:2], 2'b00};
        2'd1:    dst_nxt_s = {csr_writedata[ADDR_W-1:2], 2'b00};
        2'd2:    len_nxt_s = csr_writedata[LEN_W-1:0];
        default: len_nxt_s = len_r;
      endcase
    end else begin
      len_nxt_s = len_r;
    end

    if (ctrl_wr_s) begin
      irq_en_nxt_s = csr_writedata[1];
    end else begin
      irq_en_nxt_s = irq_en_r;
    end
    if (ctrl_wr_s && csr_writedata[2]) begin
      done_nxt_s = 1'b0;
    end else begin
      done_nxt_s = done_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (go_s) begin
          if (word_cnt_s != {WCNT_W{1'b0}}) begin
            state_nxt_s  = ST_RUN;
            rd_ptr_nxt_s = src_r;
            wr_ptr_nxt_s = dst_r;
            rd_rem_nxt_s = word_cnt_s;
            wr_rem_nxt_s = word_cnt_s;
            done_nxt_s   = 1'b0;
          end else begin
            done_nxt_s   = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (rd_acc_s) begin
          rd_ptr_nxt_s = rd_ptr_r + WORD_BYTES;
          rd_rem_nxt_s = rd_rem_r - WCNT_W'(1);
        end else begin
          rd_ptr_nxt_s = rd_ptr_r;
        end
        if (wr_acc_s) begin
          wr_ptr_nxt_s = wr_ptr_r + WORD_BYTES;
          wr_rem_nxt_s = wr_rem_r - WCNT_W'(1);
        end else begin
          wr_ptr_nxt_s = wr_ptr_r;
        end
        if (last_wr_s) begin
          state_nxt_s = ST_IDLE;
          done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Data path: FIFO occupancy, registered head word and look-ahead bus request strobes.
  always_comb begin
    outst_nxt_s = outst_r + CNT_W'(rd_acc_s) - CNT_W'(push_s);
    count_nxt_s = count_r + CNT_W'(push_s) - CNT_W'(wr_acc_s);
    head_nxt_s  = head_r + PTR_W'(wr_acc_s);
    tail_nxt_s  = tail_r + PTR_W'(push_s);
    remain_s    = count_r - CNT_W'(wr_acc_s);
    credit_s    = {1'b0, outst_nxt_s} + {1'b0, count_nxt_s};

    // When the only entry left is the one arriving now, bypass the memory.
    if (count_nxt_s == {CNT_W{1'b0}}) begin
      wr_data_nxt_s = wr_data_r;
    end else if (remain_s == {CNT_W{1'b0}}) begin
      wr_data_nxt_s = rd_readdata;
    end else begin
      wr_data_nxt_s = mem_r[head_nxt_s];
    end

    rd_read_nxt_s  = (state_nxt_s == ST_RUN) && (rd_rem_nxt_s != {WCNT_W{1'b0}}) &&
                     (credit_s < DEPTH_C);
    wr_write_nxt_s = (state_nxt_s == ST_RUN) && (count_nxt_s != {CNT_W{1'b0}});
    irq_nxt_s      = done_nxt_s && irq_en_nxt_s;

    if (csr_read) begin
      case (csr_address)
        2'd0:    csr_rdata_nxt_s = 32'(src_r);
        2'd1:    csr_rdata_nxt_s = 32'(dst_r);
        2'd2:    csr_rdata_nxt_s = 32'(len_r);
        default: csr_rdata_nxt_s = {29'd0, done_r, irq_en_r, (state_r == ST_RUN)};
      endcase
    end else begin
      csr_rdata_nxt_s = csr_rdata_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      src_r       <= {ADDR_W{1'b0}};
      dst_r       <= {ADDR_W{1'b0}};
      len_r       <= {LEN_W{1'b0}};
      irq_en_r    <= 1'b0;
      done_r      <= 1'b0;
      rd_ptr_r    <= {ADDR_W{1'b0}};
      wr_ptr_r    <= {ADDR_W{1'b0}};
      rd_rem_r    <= {WCNT_W{1'b0}};
      wr_rem_r    <= {WCNT_W{1'b0}};
      outst_r     <= {CNT_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      head_r      <= {PTR_W{1'b0}};
      tail_r      <= {PTR_W{1'b0}};
      wr_data_r   <= {DATA_W{1'b0}};
      rd_read_r   <= 1'b0;
      wr_write_r  <= 1'b0;
      irq_r       <= 1'b0;
      csr_rdata_r <= 32'd0;
    end else begin
      state_r     <= state_nxt_s;
      src_r       <= src_nxt_s;
      dst_r       <= dst_nxt_s;
      len_r       <= len_nxt_s;
      irq_en_r    <= irq_en_nxt_s;
      done_r      <= done_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_rem_r    <= rd_rem_nxt_s;
      wr_rem_r    <= wr_rem_nxt_s;
      outst_r     <= outst_nxt_s;
      count_r     <= count_nxt_s;
      head_r      <= head_nxt_s;
      tail_r      <= tail_nxt_s;
      wr_data_r   <= wr_data_nxt_s;
      rd_read_r   <= rd_read_nxt_s;
      wr_write_r  <= wr_write_nxt_s;
      irq_r       <= irq_nxt_s;
      csr_rdata_r <= csr_rdata_nxt_s;
    end
  end

  // FIFO storage; contents are meaningless outside the head/tail window so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[tail_r] <= rd_readdata;
    end
  end

  assign csr_readdata = csr_rdata_r;
  assign rd_address   = rd_ptr_r;
  assign rd_read      = rd_read_r;
  assign wr_address   = wr_ptr_r;
  assign wr_write     = wr_write_r;
  assign wr_writedata = wr_data_r;
  assign irq          = irq_r;

endmodule
